// File: rtl/frequency_counter_autorange.sv
// frequency_counter_autorange
// Auto-ranging controller for the frequency counter: holds the measurement
// counter in reset for a settle window after every gate or range change,
// evaluates Cntover/Cntlow at the end of each gate, and steps the range with
// hysteresis. Flags report inputs beyond the top or bottom range.
// Optional manual range override is compiled in with FREQ_AUTORANGE_MANUAL_EN.
module frequency_counter_autorange #(
    parameter int N_RANGES   = 3,
    parameter int IDX_W      = 2,
    parameter int INIT_RANGE = 1,
    parameter int SETTLE_CYC = 1,
    parameter int HYST       = 1
) (
    input  logic                Clk,
    input  logic                Clear_n,
    input  logic                Cntover,
    input  logic                Cntlow,
    input  logic                Gate_done,
`ifdef FREQ_AUTORANGE_MANUAL_EN
    input  logic                Manual,
    input  logic [IDX_W-1:0]    Man_range,
`endif
    output logic                reset,
    output logic [IDX_W-1:0]    std_f_sel,
    output logic [IDX_W-1:0]    range_idx,
    output logic [N_RANGES-1:0] range,
    output logic                meas_valid,
    output logic                over_flag,
    output logic                under_flag
);

    localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(N_RANGES - 1);
    localparam logic [IDX_W-1:0]    INIT_IDX    = IDX_W'(INIT_RANGE);
    localparam logic [4:0]          HYST_V      = 5'(HYST);

    // One-hot encodings keep illegal patterns detectable by the default branch.
    typedef enum logic [1:0] {
        ST_SETTLE  = 2'b01,
        ST_MEASURE = 2'b10
    } state_t;

    state_t                state, state_nx;
    logic [SETTLE_W-1:0]   settle_cnt, settle_nx;
    logic [IDX_W-1:0]      idx_nx;
    logic [3:0]            over_cnt, over_cnt_nx;
    logic [3:0]            low_cnt, low_cnt_nx;
    logic                  over_flag_nx, under_flag_nx, meas_valid_nx;
    logic                  auto_en;
    logic                  over_hit, low_hit;

    // Hysteresis counters stop at 15 instead of wrapping back to zero.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

`ifdef FREQ_AUTORANGE_MANUAL_EN
    logic [IDX_W-1:0] man_idx;
    assign man_idx = (Man_range > LAST_IDX) ? LAST_IDX : Man_range;
    assign auto_en = ~Manual;
`else
    assign auto_en = 1'b1;
`endif

    assign over_hit  = ({1'b0, over_cnt} + 5'd1) == HYST_V;
    assign low_hit   = ({1'b0, low_cnt} + 5'd1) == HYST_V;
    assign reset     = (state != ST_MEASURE);
    assign std_f_sel = range_idx;

    // Range indication: one-hot decode of the current range index.
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        range = '0;
        for (int i = 0; i < N_RANGES; i++) begin
            range[i] = (range_idx == IDX_W'(i));
        end
    end

    // Next-state, range stepping, hysteresis and flag evaluation.
    always_comb begin
        state_nx      = state;
        settle_nx     = settle_cnt;
        idx_nx        = range_idx;
        over_cnt_nx   = over_cnt;
        low_cnt_nx    = low_cnt;
        over_flag_nx  = over_flag;
        under_flag_nx = under_flag;
        meas_valid_nx = 1'b0;

        case (state)
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nx = ST_MEASURE;
                end else begin
                    settle_nx = settle_cnt + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (Gate_done) begin
                    state_nx  = ST_SETTLE;
                    settle_nx = '0;
                    if (Cntover) begin
                        if (auto_en && range_idx != '0) begin
                            if (over_hit) begin
                                idx_nx      = range_idx - 1'b1;
                                over_cnt_nx = '0;
                            end else begin
                                over_cnt_nx = sat_inc(over_cnt);
                            end
                            low_cnt_nx = '0;
                        end else begin
                            over_flag_nx  = 1'b1;
                            under_flag_nx = 1'b0;
                            meas_valid_nx = 1'b1;
                            over_cnt_nx   = '0;
                            low_cnt_nx    = '0;
                        end
                    end else if (Cntlow) begin
                        if (auto_en && range_idx != LAST_IDX) begin
                            if (low_hit) begin
                                idx_nx     = range_idx + 1'b1;
                                low_cnt_nx = '0;
                            end else begin
                                low_cnt_nx = sat_inc(low_cnt);
                            end
                            over_cnt_nx = '0;
                        end else begin
                            over_flag_nx  = 1'b0;
                            under_flag_nx = 1'b1;
                            meas_valid_nx = 1'b1;
                            over_cnt_nx   = '0;
                            low_cnt_nx    = '0;
                        end
                    end else begin
                        over_flag_nx  = 1'b0;
                        under_flag_nx = 1'b0;
                        meas_valid_nx = 1'b1;
                        over_cnt_nx   = '0;
                        low_cnt_nx    = '0;
                    end
                end
            end
            default: begin
                state_nx  = ST_SETTLE;
                settle_nx = '0;
            end
        endcase

`ifdef FREQ_AUTORANGE_MANUAL_EN
        // A manual range change restarts the settle window; the pending gate is dropped.
        if (Manual && man_idx != range_idx) begin
            idx_nx        = man_idx;
            state_nx      = ST_SETTLE;
            settle_nx     = '0;
            meas_valid_nx = 1'b0;
            over_cnt_nx   = '0;
            low_cnt_nx    = '0;
        end
`endif
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            range_idx  <= INIT_IDX;
            over_cnt   <= '0;
            low_cnt    <= '0;
            over_flag  <= 1'b0;
            under_flag <= 1'b0;
            meas_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state      <= state_nx;
            settle_cnt <= settle_nx;
            range_idx  <= idx_nx;
            over_cnt   <= over_cnt_nx;
            low_cnt    <= low_cnt_nx;
            over_flag  <= over_flag_nx;
            under_flag <= under_flag_nx;
            meas_valid <= meas_valid_nx;
        end
    end

endmodule

// File: tb/tb_frequency_counter_autorange.sv
// Bench for frequency_counter_autorange: table-driven windows on two
// configurations, hand-written reset sequences, and a randomized phase
// compared against a window-level reference model.
// The manual-override test is compiled in with FREQ_AUTORANGE_MANUAL_EN.
module tb_frequency_counter_autorange;

    localparam int A_N = 3, A_HYST = 1, A_SETTLE = 1;
    localparam int B_N = 3, B_HYST = 3, B_SETTLE = 2;
    localparam int INIT = 1;

    logic Clk = 1'b0;
    logic Clear_n = 1'b0;
    logic a_over = 1'b0, a_low = 1'b0, a_gate = 1'b0;
    logic b_over = 1'b0, b_low = 1'b0, b_gate = 1'b0;
    logic       a_reset, b_reset;
    logic [1:0] a_sel, a_idx, b_sel, b_idx;
    logic [2:0] a_range, b_range;
    logic       a_mv, a_of, a_uf, b_mv, b_of, b_uf;
`ifdef FREQ_AUTORANGE_MANUAL_EN
    logic       a_manual = 1'b0, b_manual = 1'b0;
    logic [1:0] a_man_range = 2'd0, b_man_range = 2'd0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    frequency_counter_autorange #(
        .N_RANGES(A_N), .IDX_W(2), .INIT_RANGE(INIT), .SETTLE_CYC(A_SETTLE), .HYST(A_HYST)
    ) dut_a (
        .Clk(Clk), .Clear_n(Clear_n), .Cntover(a_over), .Cntlow(a_low), .Gate_done(a_gate),
`ifdef FREQ_AUTORANGE_MANUAL_EN
        .Manual(a_manual), .Man_range(a_man_range),
`endif
        .reset(a_reset), .std_f_sel(a_sel), .range_idx(a_idx), .range(a_range),
        .meas_valid(a_mv), .over_flag(a_of), .under_flag(a_uf)
    );

    frequency_counter_autorange #(
        .N_RANGES(B_N), .IDX_W(2), .INIT_RANGE(INIT), .SETTLE_CYC(B_SETTLE), .HYST(B_HYST)
    ) dut_b (
        .Clk(Clk), .Clear_n(Clear_n), .Cntover(b_over), .Cntlow(b_low), .Gate_done(b_gate),
`ifdef FREQ_AUTORANGE_MANUAL_EN
        .Manual(b_manual), .Man_range(b_man_range),
`endif
        .reset(b_reset), .std_f_sel(b_sel), .range_idx(b_idx), .range(b_range),
        .meas_valid(b_mv), .over_flag(b_of), .under_flag(b_uf)
    );

    // Window-level reference: a settle countdown, a directional streak of
    // out-of-range windows, and the flags of the last accepted window.
    typedef struct {
        int idx;
        int settle_left;
        int streak_dir;
        int streak_len;
        bit mv;
        bit of;
        bit uf;
    } model_t;

    function automatic model_t model_init(input int settle);
        model_t m;
        m.idx = INIT; m.settle_left = settle; m.streak_dir = 0; m.streak_len = 0;
        m.mv = 1'b0; m.of = 1'b0; m.uf = 1'b0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input bit gate, input bit over,
                                          input bit low, input int n, input int hyst,
                                          input int settle);
        model_t r;
        int dir;
        bit can_move;
        r = m;
        r.mv = 1'b0;
        if (r.settle_left > 0) begin
            r.settle_left--;
        end else if (gate) begin
            dir = over ? 1 : (low ? -1 : 0);
            can_move = (dir == 1 && r.idx > 0) || (dir == -1 && r.idx < n - 1);
            r.settle_left = settle;
            if (can_move) begin
                if (r.streak_dir == dir) r.streak_len++;
                else begin r.streak_dir = dir; r.streak_len = 1; end
                if (r.streak_len >= hyst) begin
                    r.idx = r.idx - dir;
                    r.streak_dir = 0;
                    r.streak_len = 0;
                end
            end else begin
                r.mv = 1'b1;
                r.of = (dir == 1);
                r.uf = (dir == -1);
                r.streak_dir = 0;
                r.streak_len = 0;
            end
        end
        return r;
    endfunction

    function automatic logic [10:0] model_outs(input model_t m);
        logic [1:0] i2;
        i2 = 2'(m.idx);
        return {m.settle_left > 0, i2, i2, 3'(1 << m.idx), m.mv, m.of, m.uf};
    endfunction

    model_t ma = model_init(A_SETTLE);
    model_t mb = model_init(B_SETTLE);

    always @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            ma <= model_init(A_SETTLE);
            mb <= model_init(B_SETTLE);
        end else begin
            ma <= model_step(ma, a_gate, a_over, a_low, A_N, A_HYST, A_SETTLE);
            mb <= model_step(mb, b_gate, b_over, b_low, B_N, B_HYST, B_SETTLE);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for MEASURE, pulses Gate_done once, then checks the evaluation
    // result and the length of the following settle window.
    task automatic window(input bit which, input bit over, input bit low, input int exp_idx,
                          input bit exp_mv, input bit exp_of, input bit exp_uf,
                          input string tag);
        int settle;
        bit ok;
        logic [2:0] exp_range;
        settle = which ? B_SETTLE : A_SETTLE;
        exp_range = 3'(1 << exp_idx);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if ((which ? b_reset : a_reset) == 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        check({tag, " reach_measure"}, 32'(ok), 32'd1);
        if (which) begin b_gate = 1'b1; b_over = over; b_low = low; end
        else       begin a_gate = 1'b1; a_over = over; a_low = low; end
        @(negedge Clk);
        b_gate = 1'b0; b_over = 1'b0; b_low = 1'b0;
        a_gate = 1'b0; a_over = 1'b0; a_low = 1'b0;
        check({tag, " idx"},   32'(which ? b_idx : a_idx), 32'(exp_idx));
        check({tag, " sel"},   32'(which ? b_sel : a_sel), 32'(exp_idx));
        check({tag, " range"}, 32'(which ? b_range : a_range), 32'(exp_range));
        check({tag, " mv"},    32'(which ? b_mv : a_mv), 32'(exp_mv));
        check({tag, " of"},    32'(which ? b_of : a_of), 32'(exp_of));
        check({tag, " uf"},    32'(which ? b_uf : a_uf), 32'(exp_uf));
        check({tag, " reset"}, 32'(which ? b_reset : a_reset), 32'd1);
        for (int k = 1; k < settle; k++) begin
            @(negedge Clk);
            check({tag, " settle_reset"}, 32'(which ? b_reset : a_reset), 32'd1);
            check({tag, " settle_mv"},    32'(which ? b_mv : a_mv), 32'd0);
        end
        @(negedge Clk);
        check({tag, " measure_reset"}, 32'(which ? b_reset : a_reset), 32'd0);
        check({tag, " measure_mv"},    32'(which ? b_mv : a_mv), 32'd0);
    endtask

    typedef struct {
        bit which;
        bit over;
        bit low;
        int idx;
        bit mv;
        bit of;
        bit uf;
    } vec_t;

    vec_t vecs[23];

    initial begin
        // A: HYST=1, starts in range 1.  B: HYST=3, SETTLE_CYC=2, starts in range 1.
        vecs[0]  = '{0, 0, 0, 1, 1, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 0, 1, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 1, 1, 0, 0, 0};
        vecs[5]  = '{0, 0, 1, 2, 0, 0, 0};
        vecs[6]  = '{0, 0, 1, 2, 1, 0, 1};
        vecs[7]  = '{0, 1, 1, 1, 0, 0, 1};
        vecs[8]  = '{0, 1, 1, 0, 0, 0, 1};
        vecs[9]  = '{0, 1, 1, 0, 1, 1, 0};
        vecs[10] = '{1, 0, 1, 1, 0, 0, 0};
        vecs[11] = '{1, 0, 1, 1, 0, 0, 0};
        vecs[12] = '{1, 0, 0, 1, 1, 0, 0};
        vecs[13] = '{1, 0, 1, 1, 0, 0, 0};
        vecs[14] = '{1, 0, 1, 1, 0, 0, 0};
        vecs[15] = '{1, 0, 1, 2, 0, 0, 0};
        vecs[16] = '{1, 0, 1, 2, 1, 0, 1};
        vecs[17] = '{1, 1, 0, 2, 0, 0, 1};
        vecs[18] = '{1, 1, 0, 2, 0, 0, 1};
        vecs[19] = '{1, 0, 1, 2, 1, 0, 1};
        vecs[20] = '{1, 1, 0, 2, 0, 0, 1};
        vecs[21] = '{1, 1, 0, 2, 0, 0, 1};
        vecs[22] = '{1, 1, 1, 1, 0, 0, 1};

        // Reset state while Clear_n is held low.
        @(negedge Clk);
        check("rst reset", 32'(a_reset), 32'd1);
        check("rst range", 32'(a_range), 32'b010);
        check("rst sel",   32'(a_sel),   32'd1);
        check("rst flags", 32'({a_mv, a_of, a_uf}), 32'd0);
        check("rst b idx", 32'(b_idx),   32'd1);
        Clear_n = 1'b1;
        #1;
        check("rel reset_hi", 32'(a_reset), 32'd1);
        @(negedge Clk);
        check("rel reset_lo", 32'(a_reset), 32'd0);

        for (int i = 0; i < 23; i++) begin
            window(vecs[i].which, vecs[i].over, vecs[i].low, vecs[i].idx,
                   vecs[i].mv, vecs[i].of, vecs[i].uf, $sformatf("vec%0d", i));
        end

        // Clear_n mid-MEASURE: both instances return to the initial range at once.
        #2 Clear_n = 1'b0;
        #1;
        check("midclr a reset", 32'(a_reset), 32'd1);
        check("midclr a idx",   32'(a_idx),   32'd1);
        check("midclr a range", 32'(a_range), 32'b010);
        check("midclr a flags", 32'({a_mv, a_of, a_uf}), 32'd0);
        check("midclr b reset", 32'(b_reset), 32'd1);
        check("midclr b idx",   32'(b_idx),   32'd1);
        check("midclr b flags", 32'({b_mv, b_of, b_uf}), 32'd0);
        @(negedge Clk);
        Clear_n = 1'b1;

        // Randomized gates against the reference model.
        for (int c = 0; c < 600; c++) begin
            @(negedge Clk);
            check($sformatf("rand a cyc%0d", c),
                  32'({a_reset, a_idx, a_sel, a_range, a_mv, a_of, a_uf}), 32'(model_outs(ma)));
            check($sformatf("rand b cyc%0d", c),
                  32'({b_reset, b_idx, b_sel, b_range, b_mv, b_of, b_uf}), 32'(model_outs(mb)));
            a_gate = ($urandom_range(0, 2) == 0);
            a_over = ($urandom_range(0, 9) < 4);
            a_low  = ($urandom_range(0, 9) < 4);
            b_gate = ($urandom_range(0, 2) == 0);
            b_over = ($urandom_range(0, 9) < 4);
            b_low  = ($urandom_range(0, 9) < 4);
        end
        @(negedge Clk);
        a_gate = 1'b0; a_over = 1'b0; a_low = 1'b0;
        b_gate = 1'b0; b_over = 1'b0; b_low = 1'b0;

`ifdef FREQ_AUTORANGE_MANUAL_EN
        // Manual selection beyond the top index clamps and forces a settle window.
        @(negedge Clk);
        a_manual = 1'b1;
        a_man_range = 2'd3;
        @(negedge Clk);
        check("man idx",   32'(a_idx),   32'd2);
        check("man range", 32'(a_range), 32'b100);
        check("man reset", 32'(a_reset), 32'd1);
        window(1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, "man over1");
        window(1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, "man over2");
        window(1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, "man inrange");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
